// File: rtl/ddr_burst_ctrl_v2.sv
// rtl/ddr_burst_ctrl_v2.sv - burst request to MIG app_* command/write-data controller
// Optional stall watchdog with burst_timeout output: define DDR_TIMEOUT_EN.
module ddr_burst_ctrl_v2 #(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int LEN_WIDTH      = 10,
  parameter int ADDR_STEP      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rd_burst_req,
  input  logic [LEN_WIDTH-1:0]        rd_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0]   rd_burst_addr,
  output logic [DDR_DATA_WIDTH-1:0]   rd_burst_data,
  output logic                        rd_burst_data_valid,
  output logic                        rd_burst_finish,
  input  logic                        wr_burst_req,
  input  logic [LEN_WIDTH-1:0]        wr_burst_len,
  input  logic [DDR_ADDR_WIDTH-1:0]   wr_burst_addr,
  input  logic [DDR_DATA_WIDTH-1:0]   wr_burst_data,
  output logic                        wr_burst_data_req,
  output logic                        wr_burst_finish,
  output logic                        burst_finish,
  output logic                        busy,
`ifdef DDR_TIMEOUT_EN
  output logic                        burst_timeout,
`endif
  output logic [DDR_ADDR_WIDTH-1:0]   app_addr,
  output logic [2:0]                  app_cmd,
  output logic                        app_en,
  output logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
  output logic                        app_wdf_end,
  output logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                        app_wdf_wren,
  input  logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
  input  logic                        app_rd_data_valid,
  input  logic                        app_rdy,
  input  logic                        app_wdf_rdy,
  input  logic                        init_calib_complete
);

  typedef enum logic [2:0] {IDLE, RD_RUN, RD_END, WR_RUN, WR_END} state_t;

  state_t               state, state_next;
  logic [LEN_WIDTH-1:0] len_q, cmd_cnt, data_cnt, cmd_cnt_nx, data_cnt_nx;
  logic                 prefer_wr, grant_rd, grant_wr, cmd_hs, data_beat, timeout_hit;

  assign cmd_hs              = app_en & app_rdy;
  // Beats outside RD_RUN belong to an aborted burst and are dropped
  assign rd_burst_data_valid = app_rd_data_valid & (state == RD_RUN);
  assign rd_burst_data       = app_rd_data;
  assign app_wdf_wren        = (state == WR_RUN) && (data_cnt < len_q);
  assign app_wdf_end         = app_wdf_wren;
  assign app_wdf_data        = wr_burst_data;
  assign app_wdf_mask        = '0;
  assign wr_burst_data_req   = app_wdf_wren & app_wdf_rdy;
  assign data_beat           = rd_burst_data_valid | wr_burst_data_req;
  assign cmd_cnt_nx          = cmd_cnt + LEN_WIDTH'(cmd_hs);
  assign data_cnt_nx         = data_cnt + LEN_WIDTH'(data_beat);
  assign rd_burst_finish     = (state == RD_END);
  assign wr_burst_finish     = (state == WR_END);
  assign burst_finish        = rd_burst_finish | wr_burst_finish;
  assign busy                = (state != IDLE);

`ifdef DDR_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;
  logic               in_run, activity;

  assign in_run      = (state == RD_RUN) || (state == WR_RUN);
  assign activity    = cmd_hs | wr_burst_data_req | app_rd_data_valid;
  assign timeout_hit = in_run && !activity && (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= '0;
      burst_timeout <= 1'b0;
    end else begin
      stall_cnt     <= (!in_run || activity) ? '0 : stall_cnt + 1'b1;
      // Registered so it lines up with the END-state finish pulse
      burst_timeout <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (init_calib_complete) begin
          if (rd_burst_req && (!wr_burst_req || !prefer_wr)) grant_rd = 1'b1;
          else if (wr_burst_req)                              grant_wr = 1'b1;
        end
        if (grant_rd)      state_next = (rd_burst_len == '0) ? RD_END : RD_RUN;
        else if (grant_wr) state_next = (wr_burst_len == '0) ? WR_END : WR_RUN;
      end
      RD_RUN: if (timeout_hit || data_cnt_nx == len_q) state_next = RD_END;
      WR_RUN: if (timeout_hit || (cmd_cnt_nx == len_q && data_cnt_nx == len_q)) state_next = WR_END;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      cmd_cnt   <= '0;
      data_cnt  <= '0;
      app_addr  <= '0;
      app_cmd   <= 3'b000;
      app_en    <= 1'b0;
      prefer_wr <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_rd || grant_wr) begin
        len_q     <= grant_rd ? rd_burst_len : wr_burst_len;
        app_addr  <= grant_rd ? rd_burst_addr : wr_burst_addr;
        app_cmd   <= grant_rd ? 3'b001 : 3'b000;
        app_en    <= grant_rd ? (rd_burst_len != '0) : (wr_burst_len != '0);
        cmd_cnt   <= '0;
        data_cnt  <= '0;
        prefer_wr <= grant_rd;
      end else begin
        cmd_cnt  <= cmd_cnt_nx;
        data_cnt <= data_cnt_nx;
        if (cmd_hs) app_addr <= app_addr + DDR_ADDR_WIDTH'(ADDR_STEP);
        if ((cmd_hs && cmd_cnt_nx == len_q) ||
            (state_next != RD_RUN && state_next != WR_RUN)) app_en <= 1'b0;
      end
    end
  end

endmodule
